// File: rtl/flash_bus_arbiter.sv
// Purpose : two-port arbiter and cycle sequencer for an asynchronous 16-bit NOR flash.
// Latency : read done at T+1+READ_WAIT_CYC, write done at T+3+WE_PULSE_CYC (T = acceptance edge).
// Backpressure: reqN_ready_out is high only in IDLE for the granted port; other requests wait.
//
// Ports:
//   fx2Clk_in / reset_btn          clock, synchronous active-high reset
//   reqN_valid/write/addr/wdata_in request from port N (0 = host/USB, 1 = on-chip reader)
//   reqN_ready_out                 combinational acceptance (valid & ready on an edge)
//   rspN_done_out / rspN_rdata_out one-cycle completion pulse, read data held until next read
//   flash_*                        flash pins; data bus tri-state is resolved at the top level
//
// Optional feature: define FLASH_ARB_FIXED_PRIO_EN to make port 0 win every tie
// (round-robin otherwise).
module flash_bus_arbiter #(
  parameter int ADDR_W        = 26,
  parameter int DATA_W        = 16,
  parameter int READ_WAIT_CYC = 4,
  parameter int WE_PULSE_CYC  = 3
) (
  input  logic              fx2Clk_in,
  input  logic              reset_btn,
  input  logic              req0_valid_in,
  input  logic              req0_write_in,
  input  logic [ADDR_W-1:0] req0_addr_in,
  input  logic [DATA_W-1:0] req0_wdata_in,
  output logic              req0_ready_out,
  output logic              rsp0_done_out,
  output logic [DATA_W-1:0] rsp0_rdata_out,
  input  logic              req1_valid_in,
  input  logic              req1_write_in,
  input  logic [ADDR_W-1:0] req1_addr_in,
  input  logic [DATA_W-1:0] req1_wdata_in,
  output logic              req1_ready_out,
  output logic              rsp1_done_out,
  output logic [DATA_W-1:0] rsp1_rdata_out,
  output logic [ADDR_W-1:0] flash_address_out,
  output logic [DATA_W-1:0] flash_data_out,
  input  logic [DATA_W-1:0] flash_data_in,
  output logic              flash_data_oe_out,
  output logic              flash_ce_n_out,
  output logic              flash_oe_n_out,
  output logic              flash_we_n_out,
  output logic              flash_rst_n_out
);

  typedef enum logic [2:0] {IDLE, RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD, TURN} state_t;

  localparam logic [7:0] RD_CNT = 8'(READ_WAIT_CYC);
  localparam logic [7:0] WR_CNT = 8'(WE_PULSE_CYC);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              last_served_q, last_served_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d, data_oe_q, data_oe_d;
  logic              done0_q, done0_d, done1_q, done1_d;
  logic              rst_n_q;

  logic grant_vld, grant_port;

  // A lone requester is always granted; a tie goes to the port not served last
  // (or to port 0 when fixed priority is built in).
  always_comb begin
    grant_vld  = req0_valid_in | req1_valid_in;
    grant_port = req1_valid_in & ~req0_valid_in;
    if (req0_valid_in && req1_valid_in) begin
`ifdef FLASH_ARB_FIXED_PRIO_EN
      grant_port = 1'b0;
`else
      grant_port = ~last_served_q;
`endif
    end
  end

  assign req0_ready_out = (state_q == IDLE) && req0_valid_in && !grant_port;
  assign req1_ready_out = (state_q == IDLE) && req1_valid_in &&  grant_port;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    owner_d       = owner_q;
    last_served_d = last_served_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          owner_d       = grant_port;
          last_served_d = grant_port;
          addr_d        = grant_port ? req1_addr_in  : req0_addr_in;
          wdata_d       = grant_port ? req1_wdata_in : req0_wdata_in;
          if (grant_port ? req1_write_in : req0_write_in) begin
            state_d = WR_SETUP;
            cnt_d   = WR_CNT;
          end else begin
            state_d = RD_WAIT;
            cnt_d   = RD_CNT;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == 8'd1) begin
          state_d = TURN;
          if (owner_q) rdata1_d = flash_data_in;
          else         rdata0_d = flash_data_in;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      // The pulse count was loaded at acceptance and is held through setup.
      WR_SETUP: state_d = WR_PULSE;
      WR_PULSE: begin
        if (cnt_q == 8'd1) state_d = WR_HOLD;
        else               cnt_d   = cnt_q - 8'd1;
      end
      WR_HOLD: state_d = TURN;
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes are decoded from the next state and registered, so the pins are
    // glitch-free and change on the same edge as the state.
    ce_n_d    = !(state_d == RD_WAIT || state_d == WR_SETUP ||
                  state_d == WR_PULSE || state_d == WR_HOLD);
    oe_n_d    = !(state_d == RD_WAIT);
    we_n_d    = !(state_d == WR_PULSE);
    data_oe_d = (state_d == WR_SETUP) || (state_d == WR_PULSE) || (state_d == WR_HOLD);
    done0_d   = (state_d == TURN) && !owner_d;
    done1_d   = (state_d == TURN) &&  owner_d;
  end

  always_ff @(posedge fx2Clk_in) begin
    if (reset_btn) begin
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      owner_q       <= 1'b0;
      last_served_q <= 1'b1;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      ce_n_q        <= 1'b1;
      oe_n_q        <= 1'b1;
      we_n_q        <= 1'b1;
      data_oe_q     <= 1'b0;
      done0_q       <= 1'b0;
      done1_q       <= 1'b0;
      rst_n_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      owner_q       <= owner_d;
      last_served_q <= last_served_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
      ce_n_q        <= ce_n_d;
      oe_n_q        <= oe_n_d;
      we_n_q        <= we_n_d;
      data_oe_q     <= data_oe_d;
      done0_q       <= done0_d;
      done1_q       <= done1_d;
      rst_n_q       <= 1'b1;
    end
  end

  assign flash_address_out = addr_q;
  assign flash_data_out    = wdata_q;
  assign flash_data_oe_out = data_oe_q;
  assign flash_ce_n_out    = ce_n_q;
  assign flash_oe_n_out    = oe_n_q;
  assign flash_we_n_out    = we_n_q;
  assign flash_rst_n_out   = rst_n_q;
  assign rsp0_done_out     = done0_q;
  assign rsp1_done_out     = done1_q;
  assign rsp0_rdata_out    = rdata0_q;
  assign rsp1_rdata_out    = rdata1_q;

`ifndef SYNTHESIS
  // Wait counts must fit the 8-bit counter and be non-zero; the flash must never
  // drive the bus while the FPGA does.
  always @(posedge fx2Clk_in) begin
    assert (READ_WAIT_CYC >= 1 && READ_WAIT_CYC <= 255)
      else $error("READ_WAIT_CYC out of range 1..255");
    assert (WE_PULSE_CYC >= 1 && WE_PULSE_CYC <= 255)
      else $error("WE_PULSE_CYC out of range 1..255");
    assert (!(!flash_oe_n_out && flash_data_oe_out))
      else $error("oe_n and data_oe active together");
    assert (!(req0_ready_out && req1_ready_out))
      else $error("both ready outputs high");
  end
`endif

endmodule
